// File: rtl/alu_input_ctrl.sv
// Operand/opcode loader and result register for the TP1 ALU board.
// Define ALU_INPUT_CTRL_FREE_ORDER_EN for unordered loading.
module alu_input_ctrl #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pulse_a,
  input  logic               pulse_b,
  input  logic               pulse_op,
  input  logic [NB_DATA-1:0] sw,
  input  logic [NB_DATA-1:0] alu_result,
  output logic [NB_DATA-1:0] data_a,
  output logic [NB_DATA-1:0] data_b,
  output logic [NB_OP-1:0]   op,
  output logic [NB_DATA-1:0] result_q,
  output logic               result_valid,
  output logic               seq_err,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    SHOW    = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [NB_DATA-1:0] data_a_q, data_a_d;
  logic [NB_DATA-1:0] data_b_q, data_b_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic [NB_DATA-1:0] result_d;
  logic               result_valid_q, result_valid_d;
  logic               seq_err_q, seq_err_d;

`ifdef ALU_INPUT_CTRL_FREE_ORDER_EN
  logic va_q, va_d;
  logic vb_q, vb_d;
  logic vo_q, vo_d;

  always_comb begin
    data_a_d       = data_a_q;
    data_b_d       = data_b_q;
    op_d           = op_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    seq_err_d      = 1'b0;
    va_d           = va_q | pulse_a;
    vb_d           = vb_q | pulse_b;
    vo_d           = vo_q | pulse_op;
    if (pulse_a)  data_a_d = sw;
    if (pulse_b)  data_b_d = sw;
    if (pulse_op) op_d     = sw[NB_OP-1:0];
    // result tracks the ALU one edge behind the operand registers
    if (va_q && vb_q && vo_q) begin
      result_d       = alu_result;
      result_valid_d = 1'b1;
    end
    state_d = (va_d && vb_d && vo_d) ? SHOW : WAIT_A;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      va_q <= 1'b0;
      vb_q <= 1'b0;
      vo_q <= 1'b0;
    end else begin
      va_q <= va_d;
      vb_q <= vb_d;
      vo_q <= vo_d;
    end
  end
`else
  logic acc, rej;

  always_comb begin
    data_a_d       = data_a_q;
    data_b_d       = data_b_q;
    op_d           = op_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    seq_err_d      = seq_err_q;
    state_d        = state_q;
    acc            = 1'b0;
    rej            = 1'b0;
    case (state_q)
      WAIT_A: begin
        acc = pulse_a;
        rej = pulse_b | pulse_op;
        if (pulse_a) begin
          data_a_d = sw;
          state_d  = WAIT_B;
        end
      end
      WAIT_B: begin
        acc = pulse_b;
        rej = pulse_a | pulse_op;
        if (pulse_b) begin
          data_b_d = sw;
          state_d  = WAIT_OP;
        end
      end
      WAIT_OP: begin
        acc = pulse_op;
        rej = pulse_a | pulse_b;
        if (pulse_op) begin
          op_d    = sw[NB_OP-1:0];
          state_d = EXEC;
        end
      end
      EXEC: begin
        rej            = pulse_a | pulse_b | pulse_op;
        result_d       = alu_result;
        result_valid_d = 1'b1;
        state_d        = SHOW;
      end
      SHOW: begin
        acc = pulse_a;
        rej = pulse_b | pulse_op;
        if (pulse_a) begin
          data_a_d       = sw;
          result_valid_d = 1'b0;
          state_d        = WAIT_B;
        end
      end
      default: state_d = WAIT_A;
    endcase
    // an error in the same cycle wins over the clear
    if (rej)      seq_err_d = 1'b1;
    else if (acc) seq_err_d = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= WAIT_A;
      data_a_q       <= '0;
      data_b_q       <= '0;
      op_q           <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      seq_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      data_a_q       <= data_a_d;
      data_b_q       <= data_b_d;
      op_q           <= op_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      seq_err_q      <= seq_err_d;
    end
  end

  assign data_a       = data_a_q;
  assign data_b       = data_b_q;
  assign op           = op_q;
  assign result_valid = result_valid_q;
  assign seq_err      = seq_err_q;
  assign state        = state_q;

endmodule
